// File: rtl/phase_diff_sched_if.sv
// rtl/phase_diff_sched_if.sv - handshake bundle between phase sources, differentiator and sink
//
// Groups every non-clock signal of phase_diff_sched.
//   in_valid  [NCH]    per-channel sample request
//   in_theta  [NCH*W]  packed phase words, channel i at [i*W +: W]
//   in_ready  [NCH]    one-hot (or zero) grant
//   ch_clear  [NCH]    per-channel history clear strobe
//   out_valid          result register holds a result
//   out_ready          sink accepts the result
//   out_ch    [CW]     channel index of the result
//   out_delta [W]      signed phase difference
//   acc_count [16]     saturating count of accepted samples
// master: sources/sink side; slave: the differentiator.
interface phase_diff_sched_if #(
    parameter int NCH = 4,
    parameter int W   = 18
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_theta;
    logic [NCH-1:0]   in_ready;
    logic [NCH-1:0]   ch_clear;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_ch;
    logic [W-1:0]     out_delta;
    logic [15:0]      acc_count;

    modport master (
        output in_valid, in_theta, ch_clear, out_ready,
        input  in_ready, out_valid, out_ch, out_delta, acc_count
    );

    modport slave (
        input  in_valid, in_theta, ch_clear, out_ready,
        output in_ready, out_valid, out_ch, out_delta, acc_count
    );
endinterface

// File: rtl/phase_diff_sched.sv
// rtl/phase_diff_sched.sv - round-robin shared phase differentiator for NCH channels
//
// Each channel keeps its previous phase word; one subtractor is time-shared by a
// round-robin arbiter. A transfer in cycle N yields out_delta = theta - prev
// (modulo 2^W) in cycle N+1.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    phase_diff_sched_if.slave (see interface file for signal list)
module phase_diff_sched #(
    parameter int NCH = 4,
    parameter int W   = 18
) (
    input  logic              clk,
    input  logic              reset,
    phase_diff_sched_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [W-1:0]   prev_q [NCH];
    logic [W-1:0]   prev_d [NCH];
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  out_ch_q, out_ch_d;
    logic [W-1:0]   out_delta_q, out_delta_d;
    logic [15:0]    acc_count_q, acc_count_d;

    logic           slot_free;
    logic           found;
    logic           xfer;
    logic [CW-1:0]  gnt_idx;
    logic [CW-1:0]  cand;
    logic [NCH-1:0] grant;
    logic [W-1:0]   theta_g;
    logic [W-1:0]   base_g;
    int             idx;

    // Arbiter and operand selection
    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        found     = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        idx       = 0;
        // Search upward from rr_ptr with wrap; first requester wins.
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            cand = CW'(idx);
            if (!found && bus.in_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        // Holding reset suppresses grants so no sample is consumed and then lost.
        xfer    = found && slot_free && !reset;
        grant   = '0;
        theta_g = '0;
        base_g  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx == CW'(i)) begin
                theta_g  = bus.in_theta[i*W +: W];
                // A clear coinciding with the transfer differentiates against zero.
                base_g   = bus.ch_clear[i] ? '0 : prev_q[i];
                grant[i] = xfer;
            end
        end
    end

    assign bus.in_ready = grant;

    // Next-state logic
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_delta_d = out_delta_q;
        acc_count_d = acc_count_q;
        for (int i = 0; i < NCH; i++) begin
            if (xfer && gnt_idx == CW'(i)) begin
                prev_d[i] = theta_g;
            end else if (bus.ch_clear[i]) begin
                prev_d[i] = '0;
            end else begin
                prev_d[i] = prev_q[i];
            end
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            out_delta_d = theta_g - base_g;
            rr_ptr_d    = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
            if (acc_count_q != 16'hFFFF) begin
                acc_count_d = acc_count_q + 16'd1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                prev_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_delta_q <= '0;
            acc_count_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                prev_q[i] <= prev_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_delta_q <= out_delta_d;
            acc_count_q <= acc_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_delta = out_delta_q;
    assign bus.acc_count = acc_count_q;

endmodule
